// File: rtl/dram_upd_pkg.sv
// Shared types and constants for the DRAM update writer.
// Contents: default address/data widths, debug counter width, FSM state type
// and state encodings.
package dram_upd_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 32;
    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEBUG_CNT_WIDTH = 16;
    localparam int unsigned STATE_WIDTH     = 2;

    typedef logic [STATE_WIDTH-1:0] upd_state_t;

    localparam upd_state_t ST_IDLE    = 2'd0;
    localparam upd_state_t ST_RD_REQ  = 2'd1;
    localparam upd_state_t ST_RD_WAIT = 2'd2;
    localparam upd_state_t ST_WR      = 2'd3;

endpackage

// File: rtl/dram_upd_adder.sv
// Combinational signed add of a stored word and an update delta.
// Build option: DRAM_UPD_SAT_EN defined -> saturating add, otherwise the sum
// wraps modulo 2^DATA_WIDTH.
// Ports:
//   i_a      signed base word
//   i_b      signed delta
//   o_sum_c  combinational result
module dram_upd_adder
    import dram_upd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_sum_c
);

`ifdef DRAM_UPD_SAT_EN
    logic [DATA_WIDTH:0] w_ext;

    // One guard bit detects overflow: guard and MSB disagree only on overflow.
    always_comb begin
        w_ext = {i_a[DATA_WIDTH-1], i_a} + {i_b[DATA_WIDTH-1], i_b};
        if (w_ext[DATA_WIDTH] != w_ext[DATA_WIDTH-1]) begin
            o_sum_c = w_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                        : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            o_sum_c = w_ext[DATA_WIDTH-1:0];
        end
    end
`else
    assign o_sum_c = i_a + i_b;
`endif

endmodule

// File: rtl/dram_update_writer.sv
// Read-modify-write engine applying sparse signed updates to DRAM words, with
// single-entry forwarding of the last written word to skip a read.
// Build option: DRAM_UPD_SAT_EN (saturating add, see dram_upd_adder).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   upd_valid/upd_ready/addr/value     update input handshake
//   mem_rd_valid/ready/addr            read request
//   mem_rsp_valid/data                 read data return (no back-pressure)
//   mem_wr_valid/ready/addr/data       write request
//   debug_fwd_hit                      pulse when an update used forwarding
//   debug_upd_count                    completed writes (wrapping)
module dram_update_writer
    import dram_upd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [ADDR_WIDTH-1:0]      upd_addr,
    input  logic [DATA_WIDTH-1:0]      upd_value,
    output logic                       mem_rd_valid,
    input  logic                       mem_rd_ready,
    output logic [ADDR_WIDTH-1:0]      mem_rd_addr,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]      mem_rsp_data,
    output logic                       mem_wr_valid,
    input  logic                       mem_wr_ready,
    output logic [ADDR_WIDTH-1:0]      mem_wr_addr,
    output logic [DATA_WIDTH-1:0]      mem_wr_data,
    output logic                       debug_fwd_hit,
    output logic [DEBUG_CNT_WIDTH-1:0] debug_upd_count
);

    upd_state_t                 r_state;
    logic                       r_upd_ready;
    logic                       r_rd_valid;
    logic                       r_wr_valid;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [DATA_WIDTH-1:0]      r_value;
    logic [DATA_WIDTH-1:0]      r_base;
    logic [DATA_WIDTH-1:0]      r_wr_data;
    logic                       r_fwd_valid;
    logic [ADDR_WIDTH-1:0]      r_fwd_addr;
    logic [DATA_WIDTH-1:0]      r_fwd_data;
    logic                       r_fwd_hit;
    logic [DEBUG_CNT_WIDTH-1:0] r_cnt;

    upd_state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]      w_addr_nxt;
    logic [DATA_WIDTH-1:0]      w_value_nxt;
    logic [DATA_WIDTH-1:0]      w_base_nxt;
    logic                       w_fwd_valid_nxt;
    logic [ADDR_WIDTH-1:0]      w_fwd_addr_nxt;
    logic [DATA_WIDTH-1:0]      w_fwd_data_nxt;
    logic                       w_fwd_hit_nxt;
    logic [DEBUG_CNT_WIDTH-1:0] w_cnt_nxt;
    logic [DATA_WIDTH-1:0]      w_sum;

    // Sum is formed from next-cycle operands so the registered write data is
    // valid on the same cycle the FSM enters WR.
    dram_upd_adder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_adder (
        .i_a     (w_base_nxt),
        .i_b     (w_value_nxt),
        .o_sum_c (w_sum)
    );

    // Next-state and holding-register update logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_value_nxt     = r_value;
        w_base_nxt      = r_base;
        w_fwd_valid_nxt = r_fwd_valid;
        w_fwd_addr_nxt  = r_fwd_addr;
        w_fwd_data_nxt  = r_fwd_data;
        w_fwd_hit_nxt   = 1'b0;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (upd_valid && r_upd_ready) begin
                    w_addr_nxt  = upd_addr;
                    w_value_nxt = upd_value;
                    if (r_fwd_valid && (upd_addr == r_fwd_addr)) begin
                        w_base_nxt    = r_fwd_data;
                        w_fwd_hit_nxt = 1'b1;
                        w_state_nxt   = ST_WR;
                    end else begin
                        w_state_nxt   = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                // Response in the handshake cycle is deliberately ignored.
                if (r_rd_valid && mem_rd_ready) begin
                    w_state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rsp_valid) begin
                    w_base_nxt  = mem_rsp_data;
                    w_state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                if (r_wr_valid && mem_wr_ready) begin
                    w_fwd_valid_nxt = 1'b1;
                    w_fwd_addr_nxt  = r_addr;
                    w_fwd_data_nxt  = r_wr_data;
                    w_cnt_nxt       = r_cnt + DEBUG_CNT_WIDTH'(1);
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; valids/ready decode the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_upd_ready <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_addr      <= '0;
            r_value     <= '0;
            r_base      <= '0;
            r_wr_data   <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
            r_fwd_hit   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_upd_ready <= (w_state_nxt == ST_IDLE);
            r_rd_valid  <= (w_state_nxt == ST_RD_REQ);
            r_wr_valid  <= (w_state_nxt == ST_WR);
            r_addr      <= w_addr_nxt;
            r_value     <= w_value_nxt;
            r_base      <= w_base_nxt;
            r_wr_data   <= w_sum;
            r_fwd_valid <= w_fwd_valid_nxt;
            r_fwd_addr  <= w_fwd_addr_nxt;
            r_fwd_data  <= w_fwd_data_nxt;
            r_fwd_hit   <= w_fwd_hit_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign upd_ready       = r_upd_ready;
    assign mem_rd_valid    = r_rd_valid;
    assign mem_rd_addr     = r_addr;
    assign mem_wr_valid    = r_wr_valid;
    assign mem_wr_addr     = r_addr;
    assign mem_wr_data     = r_wr_data;
    assign debug_fwd_hit   = r_fwd_hit;
    assign debug_upd_count = r_cnt;

endmodule

// File: tb/tb_dram_update_writer.sv
// Directed bench for dram_update_writer with a one-cycle-latency memory model.
module tb_dram_update_writer;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic          upd_valid;
    logic          upd_ready;
    logic [AW-1:0] upd_addr;
    logic [DW-1:0] upd_value;
    logic          mem_rd_valid;
    logic          mem_rd_ready;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic          mem_wr_valid;
    logic          mem_wr_ready;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          debug_fwd_hit;
    logic [15:0]   debug_upd_count;

    dram_update_writer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .upd_valid       (upd_valid),
        .upd_ready       (upd_ready),
        .upd_addr        (upd_addr),
        .upd_value       (upd_value),
        .mem_rd_valid    (mem_rd_valid),
        .mem_rd_ready    (mem_rd_ready),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .mem_wr_valid    (mem_wr_valid),
        .mem_wr_ready    (mem_wr_ready),
        .mem_wr_addr     (mem_wr_addr),
        .mem_wr_data     (mem_wr_data),
        .debug_fwd_hit   (debug_fwd_hit),
        .debug_upd_count (debug_upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory model and monitors.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic          rsp_enable = 1'b1;
    logic          man_rsp = 1'b0;
    logic [DW-1:0] man_data = '0;
    logic          rd_pend = 1'b0;
    logic [DW-1:0] rd_data_q = '0;
    int            cyc = 0;
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    int            hits = 0;
    int            wr_cyc = 0;
    logic [AW-1:0] last_rd_addr = '0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;
    logic          both_hi = 1'b0;
    int            acc_cyc = 0;

    assign mem_rsp_valid = rd_pend | man_rsp;
    assign mem_rsp_data  = rd_pend ? rd_data_q : man_data;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= 1'b0;
        if (rst_n && mem_rd_valid && mem_rd_ready) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= mem_rd_addr;
            rd_pend      <= rsp_enable;
            rd_data_q    <= mem[mem_rd_addr];
        end
        if (rst_n && mem_wr_valid && mem_wr_ready) begin
            wr_cnt       <= wr_cnt + 1;
            wr_cyc       <= cyc;
            last_wr_addr <= mem_wr_addr;
            last_wr_data <= mem_wr_data;
        end
        if (rst_n && debug_fwd_hit) hits <= hits + 1;
        if (mem_rd_valid && mem_wr_valid) both_hi <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one update and return at the falling edge after it is accepted.
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] v);
        int n;
        n = 0;
        @(negedge clk);
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_value = v;
        while (!upd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 64'(upd_ready), 64'(1));
        acc_cyc = cyc;
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int k;
        k = 0;
        while (wr_cnt < n && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("write_in_time", 64'(wr_cnt >= n), 64'(1));
    endtask

    logic [DW-1:0] exp_arith;
    int            rd_before;
    int            wr_before;
    int            k;

    initial begin
        rst_n        = 1'b0;
        upd_valid    = 1'b0;
        upd_addr     = '0;
        upd_value    = '0;
        mem_rd_ready = 1'b1;
        mem_wr_ready = 1'b1;
        mem[32'h10]  = 32'd100;
        mem[32'h20]  = 32'd10;
        mem[32'h30]  = 32'd7;
        mem[32'h40]  = 32'h7FFF_FFF0;
        mem[32'h50]  = 32'd50;
        mem[32'h60]  = 32'd60;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_upd_ready", 64'(upd_ready), 64'(0));
        check("rst_rd_valid", 64'(mem_rd_valid), 64'(0));
        check("rst_wr_valid", 64'(mem_wr_valid), 64'(0));
        check("rst_fwd_hit", 64'(debug_fwd_hit), 64'(0));
        check("rst_count", 64'(debug_upd_count), 64'(0));
        check("rst_rd_addr", 64'(mem_rd_addr), 64'(0));
        check("rst_wr_data", 64'(mem_wr_data), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 64'(upd_ready), 64'(1));

        // Read-modify-write with zero wait states.
        send(32'h10, 32'd5);
        wait_writes(1);
        check("rmw_wr_addr", 64'(last_wr_addr), 64'(32'h10));
        check("rmw_wr_data", 64'(last_wr_data), 64'(105));
        check("rmw_latency", 64'(wr_cyc - acc_cyc), 64'(3));
        check("rmw_reads", 64'(rd_cnt), 64'(1));
        check("rmw_rd_addr", 64'(last_rd_addr), 64'(32'h10));
        check("rmw_count", 64'(debug_upd_count), 64'(1));

        // Forwarding: second update to the same address skips the read.
        send(32'h20, 32'd3);
        wait_writes(2);
        check("fwd_first_data", 64'(last_wr_data), 64'(13));
        check("fwd_first_reads", 64'(rd_cnt), 64'(2));
        send(32'h20, -32'sd7);
        check("fwd_hit_pulse", 64'(debug_fwd_hit), 64'(1));
        wait_writes(3);
        check("fwd_second_data", 64'(last_wr_data), 64'(6));
        check("fwd_second_addr", 64'(last_wr_addr), 64'(32'h20));
        check("fwd_no_read", 64'(rd_cnt), 64'(2));
        check("fwd_latency", 64'(wr_cyc - acc_cyc), 64'(1));
        @(negedge clk);
        check("fwd_hit_one_cycle", 64'(debug_fwd_hit), 64'(0));
        check("fwd_count", 64'(debug_upd_count), 64'(3));

        // Back-pressure on both read and write channels.
        mem_rd_ready = 1'b0;
        mem_wr_ready = 1'b0;
        send(32'h30, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("bp_rd_valid", 64'(mem_rd_valid), 64'(1));
            check("bp_rd_addr", 64'(mem_rd_addr), 64'(32'h30));
            check("bp_rd_upd_ready", 64'(upd_ready), 64'(0));
            check("bp_rd_no_wr", 64'(mem_wr_valid), 64'(0));
            @(negedge clk);
        end
        mem_rd_ready = 1'b1;
        k = 0;
        while (!mem_wr_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("bp_reach_wr", 64'(mem_wr_valid), 64'(1));
        for (int i = 0; i < 3; i++) begin
            check("bp_wr_valid", 64'(mem_wr_valid), 64'(1));
            check("bp_wr_addr", 64'(mem_wr_addr), 64'(32'h30));
            check("bp_wr_data", 64'(mem_wr_data), 64'(8));
            check("bp_wr_upd_ready", 64'(upd_ready), 64'(0));
            check("bp_wr_no_rd", 64'(mem_rd_valid), 64'(0));
            @(negedge clk);
        end
        mem_wr_ready = 1'b1;
        wait_writes(4);
        check("bp_count", 64'(debug_upd_count), 64'(4));

        // Overflowing add.
`ifdef DRAM_UPD_SAT_EN
        exp_arith = 32'h7FFF_FFFF;
`else
        exp_arith = 32'h8000_0010;
`endif
        send(32'h40, 32'h20);
        wait_writes(5);
        check("arith_overflow", 64'(last_wr_data), 64'(exp_arith));

        // Reset while waiting for read data.
        send(32'h50, 32'd1);
        wait_writes(6);
        check("pre_rst_data", 64'(last_wr_data), 64'(51));
        rsp_enable = 1'b0;
        send(32'h60, 32'd2);
        @(negedge clk);
        check("rdwait_no_rd", 64'(mem_rd_valid), 64'(0));
        check("rdwait_no_wr", 64'(mem_wr_valid), 64'(0));
        check("rdwait_busy", 64'(upd_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", 64'(upd_ready), 64'(0));
        check("async_rst_count", 64'(debug_upd_count), 64'(0));
        check("async_rst_rd_addr", 64'(mem_rd_addr), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerelease_ready", 64'(upd_ready), 64'(1));
        wr_before = wr_cnt;
        man_data  = 32'd999;
        man_rsp   = 1'b1;
        @(negedge clk);
        man_rsp = 1'b0;
        repeat (3) @(negedge clk);
        check("late_rsp_no_write", 64'(wr_cnt), 64'(wr_before));
        check("late_rsp_no_wr_valid", 64'(mem_wr_valid), 64'(0));
        check("late_rsp_count", 64'(debug_upd_count), 64'(0));
        check("late_rsp_idle", 64'(upd_ready), 64'(1));
        rsp_enable = 1'b1;
        rd_before  = rd_cnt;
        send(32'h50, 32'd4);
        wait_writes(wr_before + 1);
        check("post_rst_reads", 64'(rd_cnt), 64'(rd_before + 1));
        check("post_rst_data", 64'(last_wr_data), 64'(54));
        check("post_rst_count", 64'(debug_upd_count), 64'(1));

        // Stray response while idle.
        @(negedge clk);
        wr_before = wr_cnt;
        man_data  = 32'd77;
        man_rsp   = 1'b1;
        @(negedge clk);
        man_rsp = 1'b0;
        check("stray_idle_ready", 64'(upd_ready), 64'(1));
        repeat (3) @(negedge clk);
        check("stray_no_write", 64'(wr_cnt), 64'(wr_before));
        check("stray_no_wr_valid", 64'(mem_wr_valid), 64'(0));
        check("stray_no_rd_valid", 64'(mem_rd_valid), 64'(0));

        check("total_fwd_hits", 64'(hits), 64'(1));
        check("rd_wr_exclusive", 64'(both_hi), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
